// File: rtl/fp_mul_arbiter_if.sv
// Request/result channel bundle for fp_mul_arbiter: packed per-requester operands
// in, tagged multiplier results out.
interface fp_mul_arbiter_if #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
);
  localparam int unsigned W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [W-1:0]         res_data;
  logic [ID_W-1:0]      res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one registered FP multiplier, credit-gated into a tagged
// result FIFO. Optional issue/stall counters enabled by FP_MUL_ARB_STATS_EN.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned MUL_LAT        = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  fp_mul_arbiter_if.slave                         bus,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  mul_a,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  mul_b,
  input  logic                                    mul_sign,
  input  logic [EXPONENT_WIDTH-1:0]               mul_exp,
  input  logic [MANTISSA_WIDTH-1:0]               mul_prod,
`ifdef FP_MUL_ARB_STATS_EN
  output logic [31:0]                             stat_issue,
  output logic [31:0]                             stat_stall,
  input  logic                                    stat_clr,
`endif
  output logic                                    busy
);
  localparam int unsigned W     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic             any_valid;
  logic             can_issue;
  logic             issue;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] cnt;
  logic [MUL_LAT:0] tag_vld;
  logic [ID_W-1:0]  tag_id [MUL_LAT+1];
  logic [W-1:0]     fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0]  fifo_id [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Credit covers in-flight ops plus buffered results, so a pop frees a slot this cycle.
  assign pop       = bus.res_valid & bus.res_ready;
  assign can_issue = !rst && ((cnt < CNT_W'(FIFO_DEPTH)) || pop);
  assign any_valid = |bus.req_valid;
  assign issue     = can_issue & any_valid;
  assign push      = tag_vld[MUL_LAT];

  // Later passes overwrite earlier ones: smallest index >= ptr wins, else smallest below ptr.
  always_comb begin
    winner = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j] && (ID_W'(j) < ptr)) winner = ID_W'(j);
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req_valid[j] && (ID_W'(j) >= ptr)) winner = ID_W'(j);
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (issue) bus.req_ready[winner] = 1'b1;
  end

  // Operand registers hold their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (issue) begin
      mul_a <= bus.req_a[32'(winner)*W +: W];
      mul_b <= bus.req_b[32'(winner)*W +: W];
    end
  end

  // Pointer, credit count and tag pipe aligned with the multiplier latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cnt     <= '0;
      tag_vld <= '0;
      for (int i = 0; i <= MUL_LAT; i++) tag_id[i] <= '0;
    end else begin
      if (issue) ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      cnt        <= cnt + CNT_W'(issue) - CNT_W'(pop);
      tag_vld[0] <= issue;
      tag_id[0]  <= winner;
      for (int i = 1; i <= MUL_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Result FIFO; storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_id[i]   <= '0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr[AW-1:0]] <= {mul_sign, mul_exp, mul_prod};
        fifo_id[wr_ptr[AW-1:0]]   <= tag_id[MUL_LAT];
        wr_ptr                    <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign bus.res_valid = (wr_ptr != rd_ptr);
  assign bus.res_data  = fifo_data[rd_ptr[AW-1:0]];
  assign bus.res_id    = fifo_id[rd_ptr[AW-1:0]];
  assign busy          = (cnt != '0);

`ifdef FP_MUL_ARB_STATS_EN
  logic stall;
  assign stall = any_valid & ~can_issue;

  // Saturating counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (issue && (stat_issue != '1)) stat_issue <= stat_issue + 32'd1;
      if (stall && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a registered single-precision multiplier model.
module tb_fp_mul_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned EW      = 8;
  localparam int unsigned MW      = 23;
  localparam int unsigned W       = EW + MW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          mul_sign;
  logic [EW-1:0] mul_exp;
  logic [MW-1:0] mul_prod;
  logic          busy;
`ifdef FP_MUL_ARB_STATS_EN
  logic [31:0]   stat_issue;
  logic [31:0]   stat_stall;
  logic          stat_clr;
`endif

  int checks   = 0;
  int failures = 0;

  fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .EXPONENT_WIDTH(EW),
                      .MANTISSA_WIDTH(MW)) bus ();

  fp_mul_arbiter dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_exp(mul_exp), .mul_prod(mul_prod),
`ifdef FP_MUL_ARB_STATS_EN
    .stat_issue(stat_issue), .stat_stall(stat_stall), .stat_clr(stat_clr),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Normal-number single-precision multiply, truncating, one register stage.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  always @(posedge clk) {mul_sign, mul_exp, mul_prod} <= fmul(mul_a, mul_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
`ifdef FP_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    rst = 1'b1;
    tick();
    tick();
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
    bus.req_valid = '0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h0) begin failures++; $display("FAIL rst_res_data: got %h want 0", bus.res_data); end
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL rst_res_id: got %0d want 0", bus.res_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin failures++; $display("FAIL rst_mul_ops: got %h/%h want 0/0", mul_a, mul_b); end
`ifdef FP_MUL_ARB_STATS_EN
    checks++; if (stat_issue !== 32'd0 || stat_stall !== 32'd0) begin failures++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_issue, stat_stall); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.res_ready = 1'b1;
    set_req(0, 32'h40400000, 32'h40000000);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    checks++; if (mul_a !== 32'h40400000 || mul_b !== 32'h40000000) begin failures++; $display("FAIL single_operands: got %h/%h want 40400000/40000000", mul_a, mul_b); end
    checks++; if (busy !== 1'b1 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_e0: got busy=%b res_valid=%b want 1/0", busy, bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_early: got res_valid=%b want 0", bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL single_latency: got res_valid=%b want 1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h40C00000 || bus.res_id !== 2'd0) begin failures++; $display("FAIL single_result: got %h id %0d want 40c00000 id 0", bus.res_data, bus.res_id); end
    tick();
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_drain: got res_valid=%b busy=%b want 0/0", bus.res_valid, busy); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_d [4];
    logic [3:0]  g;
    int          nres;
    int          bad_grant;
    int          bad_res;
    exp_d[0] = 32'h40100000;
    exp_d[1] = 32'h40C00000;
    exp_d[2] = 32'h40800000;
    exp_d[3] = 32'hC0400000;
    nres = 0; bad_grant = 0; bad_res = 0;
    do_reset();
    bus.res_ready = 1'b1;
    set_req(0, 32'h3FC00000, 32'h3FC00000);
    set_req(1, 32'h40400000, 32'h40000000);
    set_req(2, 32'h40000000, 32'h40000000);
    set_req(3, 32'hBFC00000, 32'h40000000);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i < 4) begin
        g = 4'b0001 << i;
        if (bus.req_ready !== g) bad_grant++;
      end
      if (bus.res_valid === 1'b1) begin
        if (nres >= 4 || bus.res_data !== exp_d[nres] || bus.res_id !== ID_W'(nres)) bad_res++;
        nres++;
      end
      tick();
      if (i < 4) bus.req_valid[i] = 1'b0;
    end
    checks++; if (bad_grant != 0) begin failures++; $display("FAIL contention_grant_order: got %0d wrong grants want 0", bad_grant); end
    checks++; if (bad_res != 0) begin failures++; $display("FAIL contention_results: got %0d wrong results want 0", bad_res); end
    checks++; if (nres != 4) begin failures++; $display("FAIL contention_count: got %0d results want 4", nres); end
  endtask

  task automatic test_backpressure();
    int n;
    int m;
    int bad;
    n = 0; m = 0; bad = 0;
    do_reset();
    set_req(0, 32'h40400000, 32'h40000000);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.req_ready[0] === 1'b1) n++;
      tick();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL bp_issue_count: got %0d want 4", n); end
    checks++; if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b1) begin failures++; $display("FAIL bp_stalled: got ready=%b res_valid=%b want 0000/1", bus.req_ready, bus.res_valid); end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_pop_issue: got %b want 0001", bus.req_ready); end
    tick();
    bus.res_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_restall: got %b want 0000", bus.req_ready); end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.res_valid === 1'b1) begin
        m++;
        if (bus.res_data !== 32'h40C00000) bad++;
      end
      tick();
    end
    checks++; if (m != 4 || bad != 0) begin failures++; $display("FAIL bp_drain: got %0d results %0d bad want 4 results 0 bad", m, bad); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_full_pushpop();
    int issued;
    int steady;
    int popped;
    int bad;
    issued = 0; steady = 0; popped = 0; bad = 0;
    do_reset();
    set_req(1, 32'h40400000, 32'h40000000);
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.req_ready[1] === 1'b1) issued++;
      tick();
    end
    bus.res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.req_ready[1] === 1'b1) begin issued++; steady++; end
      if (bus.res_valid === 1'b1) begin
        popped++;
        if (bus.res_id !== 2'd1 || bus.res_data !== 32'h40C00000) bad++;
      end
      tick();
    end
    checks++; if (steady != 12) begin failures++; $display("FAIL full_throughput: got %0d issues in 12 cycles want 12", steady); end
    bus.req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.res_valid === 1'b1) begin
        popped++;
        if (bus.res_id !== 2'd1 || bus.res_data !== 32'h40C00000) bad++;
      end
      tick();
    end
    checks++; if (issued != 16 || popped != 16) begin failures++; $display("FAIL full_conservation: got issued=%0d popped=%0d want 16/16", issued, popped); end
    checks++; if (bad != 0) begin failures++; $display("FAIL full_ids: got %0d bad results want 0", bad); end
  endtask

  task automatic test_reset_midflight();
    int stale;
    int nres;
    int bad;
    stale = 0; nres = 0; bad = 0;
    do_reset();
    set_req(2, 32'h40000000, 32'h40000000);
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.res_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_prefill: got res_valid=%b busy=%b want 1/1", bus.res_valid, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0 || mul_a !== 32'h0) begin failures++; $display("FAIL mid_cleared: got res_valid=%b busy=%b mul_a=%h want 0/0/0", bus.res_valid, busy, mul_a); end
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.res_valid === 1'b1) stale++;
      tick();
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL mid_stale: got %0d stale results want 0", stale); end
    set_req(2, 32'h3FC00000, 32'h3FC00000);
    set_req(3, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b1100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL mid_ptr_reset: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL mid_second_grant: got %b want 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.res_valid === 1'b1) begin
        if (nres == 0 && (bus.res_id !== 2'd2 || bus.res_data !== 32'h40100000)) bad++;
        if (nres == 1 && (bus.res_id !== 2'd3 || bus.res_data !== 32'h40400000)) bad++;
        nres++;
      end
      tick();
    end
    checks++; if (nres != 2 || bad != 0) begin failures++; $display("FAIL mid_post_results: got %0d results %0d bad want 2 results 0 bad", nres, bad); end
  endtask

`ifdef FP_MUL_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_req(0, 32'h40400000, 32'h40000000);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 7; i++) tick();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.req_valid = 4'b0001;
    tick();
    tick();
    bus.req_valid = '0;
    tick();
    checks++; if (stat_issue !== 32'd6) begin failures++; $display("FAIL stats_issue: got %0d want 6", stat_issue); end
    checks++; if (stat_stall !== 32'd3) begin failures++; $display("FAIL stats_stall: got %0d want 3", stat_stall); end
    stat_clr = 1'b1;
    bus.req_valid = 4'b0001;
    tick();
    stat_clr = 1'b0;
    bus.req_valid = '0;
    checks++; if (stat_issue !== 32'd0 || stat_stall !== 32'd0) begin failures++; $display("FAIL stats_clear: got %0d/%0d want 0/0", stat_issue, stat_stall); end
    for (int i = 0; i < 5; i++) tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_full_pushpop();
    test_reset_midflight();
`ifdef FP_MUL_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
